// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, datapath widths, opcode constants and the
// packed {pc, instr} entry carried through the prefetch buffer.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;

    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_CALL = 4'b1101;
    localparam logic [3:0] OP_RET  = 4'b1110;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FULL
    } ifu_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch circular buffer of packed entries with push/pop/clear and an occupancy count.
// Latency: a pushed entry is visible at the head the cycle after its write edge.
// Backpressure: none internal; the caller bounds occupancy, push+pop at full is legal, clear wins.
module ifu_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_vld,
    input  logic                   clear,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;

    assign do_pop   = pop_vld && (count != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= (wr_ptr + 1'b1) & PTR_MASK;
            if (do_pop)   rd_ptr <= (rd_ptr + 1'b1) & PTR_MASK;
            case ({push_vld, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_vld && !clear) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues PC+1 reads to imem, buffers returns in a prefetch FIFO, serves decode.
// Latency: 3 cycles reset-release to first instr_valid, 1 instr/cycle steady, redirect target at head 2 cycles later.
// Backpressure: instr_ready low fills DEPTH slots (read in flight included) then issue stops until a pop.
// Optional build macro IFU_PERF_CNT_EN adds saturating stall_cycles / flush_count outputs.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [15:0]        stall_cycles,
    output logic [15:0]        flush_count
`endif
);

    localparam int          CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

    ifu_state_t      state;
    ifu_state_t      state_nxt;
    logic [PC_W-1:0] fetch_pc;
    logic            epoch;
    logic            epoch_nxt;
    logic            inflight;
    logic            inflight_epoch;
    logic [PC_W-1:0] inflight_pc;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic            issue;
    logic            pop;
    logic            push;
    fetch_entry_t    head;
    fetch_entry_t    held;
    fetch_entry_t    push_entry;

    assign occupancy   = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;
    assign epoch_nxt   = epoch ^ redirect_valid;
    // A redirect clears the FIFO on this edge, so the word returning now is never kept.
    assign push        = inflight && (inflight_epoch == epoch) && !redirect_valid;
    assign push_entry  = '{pc: inflight_pc, instr: imem_rdata};

    assign imem_en   = issue;
    assign imem_addr = redirect_valid ? redirect_pc : fetch_pc;

    // Outputs hold the last presented word while the FIFO is empty.
    assign instr    = instr_valid ? head.instr : held.instr;
    assign instr_pc = instr_valid ? head.pc    : held.pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_BOOT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        if (redirect_valid) begin
            state_nxt = S_RUN;
            issue     = 1'b1;
        end else begin
            case (state)
                S_BOOT: state_nxt = S_RUN;
                S_RUN: begin
                    if (occupancy < DEPTH_LIM) issue = 1'b1;
                    else                       state_nxt = S_FULL;
                end
                S_FULL: if (pop) state_nxt = S_RUN;
                default: state_nxt = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc       <= RESET_PC;
            epoch          <= 1'b0;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_pc    <= '0;
            held           <= '0;
        end else begin
            epoch    <= epoch_nxt;
            inflight <= issue;
            if (issue) begin
                inflight_pc    <= imem_addr;
                inflight_epoch <= epoch_nxt;
                fetch_pc       <= imem_addr + 1'b1;
            end
            if (instr_valid) held <= head;
        end
    end

    ifu_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push),
        .push_dat (push_entry),
        .pop_vld  (pop),
        .clear    (redirect_valid),
        .head_dat (head),
        .count    (count)
    );

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!instr_valid && (state != S_BOOT) && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 1'b1;
            if (redirect_valid && (flush_count != 16'hFFFF))
                flush_count <= flush_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: hashed instruction memory, scoreboard of the expected PC stream,
// directed scenarios plus a randomized ready/redirect soak.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
`ifdef IFU_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int checks = 0;
    int failures = 0;
    int pops = 0;
    logic [15:0] seed = '0;
    logic [15:0] exp_pc = RESET_PC;
    bit chk_drop = 0;

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ seed ^ {a[7:0], a[15:8]};
    endfunction

    // Synchronous-read instruction memory: data one cycle after the strobe.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
    end

    // Reference model: accepted words form the stream P, P+1, ... from the last restart point.
    always @(negedge clk) begin
        if (!rst) begin
            exp_pc   = RESET_PC;
            chk_drop = 0;
        end else begin
            if (chk_drop) begin
                checks++;
                if (instr_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL valid_after_redirect got=%b want=0", instr_valid);
                end
                chk_drop = 0;
            end
            if (instr_valid && instr_ready) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                    failures++;
                    $display("FAIL stream pc=%h instr=%h want pc=%h instr=%h",
                             instr_pc, instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 16'd1;
                pops++;
            end
            if (redirect_valid) begin
                exp_pc   = redirect_pc;
                chk_drop = 1;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 0; instr_ready = 1; redirect_valid = 0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (imem_en !== 1'b0) begin failures++; $display("FAIL rst_imem_en got=%b want=0", imem_en); end
        checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL rst_imem_addr got=%h want=%h", imem_addr, RESET_PC); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_instr_valid got=%b want=0", instr_valid); end
        checks++; if (instr !== 16'h0) begin failures++; $display("FAIL rst_instr got=%h want=0000", instr); end
        checks++; if (instr_pc !== 16'h0) begin failures++; $display("FAIL rst_instr_pc got=%h want=0000", instr_pc); end
        next_cycle();
        rst = 1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (imem_en !== 1'b0) begin failures++; $display("FAIL boot_no_fetch got=%b want=0", imem_en); end
            end
            checks++;
            if (instr_valid !== (k >= 3)) begin
                failures++; $display("FAIL t1_valid cycle=%0d got=%b want=%b", k, instr_valid, k >= 3);
            end
            if (k >= 3) begin
                checks++;
                if (instr_pc !== RESET_PC + 16'(k - 3)) begin
                    failures++; $display("FAIL t1_pc cycle=%0d got=%h want=%h", k, instr_pc, RESET_PC + 16'(k - 3));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        int en_cnt;
        int gap;
        int max_gap;
        int p0;
        rst = 0; instr_ready = 0;
        next_cycle();
        rst = 1;
        en_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (imem_en) en_cnt++;
            if (k == 9) begin
                checks++;
                if (instr_valid !== 1'b1 || imem_en !== 1'b0) begin
                    failures++; $display("FAIL t2_full valid=%b imem_en=%b want 1/0", instr_valid, imem_en);
                end
            end
            next_cycle();
        end
        checks++;
        if (en_cnt != 4) begin failures++; $display("FAIL t2_issue_count got=%0d want=4", en_cnt); end
        instr_ready = 1;
        p0 = pops; gap = 0; max_gap = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (!instr_valid) gap++; else gap = 0;
            if (gap > max_gap) max_gap = gap;
            next_cycle();
        end
        checks++;
        if (max_gap > 1) begin failures++; $display("FAIL t2_drain_gap got=%0d want<=1", max_gap); end
        checks++;
        if (pops - p0 < 6) begin failures++; $display("FAIL t2_drain_count got=%0d want>=6", pops - p0); end
    endtask

    task automatic test_redirect();
        logic [15:0] shown;
        bit found;
        instr_ready = 1;
        repeat (5) next_cycle();
        redirect_valid = 1; redirect_pc = 16'h0040;
        @(negedge clk);
        shown = instr_pc;
        checks++;
        if (instr_valid !== 1'b1) begin failures++; $display("FAIL t3_streaming got=%b want=1", instr_valid); end
        next_cycle();
        redirect_valid = 0;
        @(negedge clk);
        checks++;
        if (instr_pc !== shown) begin failures++; $display("FAIL t3_hold_pc got=%h want=%h", instr_pc, shown); end
        next_cycle();
        found = 0;
        for (int w = 0; w < 6; w++) begin
            @(negedge clk);
            if (instr_valid && !found) begin
                found = 1;
                checks++;
                if (instr_pc !== 16'h0040) begin failures++; $display("FAIL t3_first got=%h want=0040", instr_pc); end
                next_cycle();
                @(negedge clk);
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 16'h0041) begin
                    failures++; $display("FAIL t3_second valid=%b pc=%h want 1/0041", instr_valid, instr_pc);
                end
            end
            next_cycle();
        end
        checks++;
        if (!found) begin failures++; $display("FAIL t3_timeout got=none want=0040"); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] tgt_a;
        logic [15:0] tgt_b;
        bit found;
        tgt_a = {OP_JMP, 12'($urandom)};
        tgt_b = {OP_CALL, 12'($urandom)};
        instr_ready = 1;
        repeat (4) next_cycle();
        redirect_valid = 1; redirect_pc = tgt_a;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1) begin failures++; $display("FAIL t4_pop_with_redirect got=%b want=1", instr_valid); end
        next_cycle();
        redirect_pc = tgt_b; instr_ready = 1'($urandom_range(0, 1));
        next_cycle();
        redirect_valid = 0; instr_ready = 1;
        found = 0;
        for (int w = 0; w < 6; w++) begin
            @(negedge clk);
            if (instr_valid && !found) begin
                found = 1;
                checks++;
                if (instr_pc !== tgt_b) begin failures++; $display("FAIL t4_second_wins got=%h want=%h", instr_pc, tgt_b); end
            end
            next_cycle();
        end
        checks++;
        if (!found) begin failures++; $display("FAIL t4_timeout got=none want=%h", tgt_b); end
    endtask

    task automatic test_wrap();
        logic [15:0] got [3];
        int n;
        instr_ready = 1;
        redirect_valid = 1; redirect_pc = 16'hFFFE;
        next_cycle();
        redirect_valid = 0;
        n = 0;
        for (int i = 0; i < 3; i++) got[i] = 16'hDEAD;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (instr_valid && instr_ready && n < 3) begin
                got[n] = instr_pc;
                n++;
            end
            next_cycle();
        end
        checks++; if (got[0] !== 16'hFFFE) begin failures++; $display("FAIL t5_pc0 got=%h want=fffe", got[0]); end
        checks++; if (got[1] !== 16'hFFFF) begin failures++; $display("FAIL t5_pc1 got=%h want=ffff", got[1]); end
        checks++; if (got[2] !== 16'h0000) begin failures++; $display("FAIL t5_pc2 got=%h want=0000", got[2]); end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 6; k++) begin
            instr_ready = 1'($urandom_range(0, 1));
            next_cycle();
        end
        instr_ready = 1;
        #1;
        rst = 0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_en !== 1'b0) begin
            failures++; $display("FAIL t6_async valid=%b imem_en=%b want 0/0", instr_valid, imem_en);
        end
        checks++;
        if (instr_pc !== 16'h0 || imem_addr !== RESET_PC) begin
            failures++; $display("FAIL t6_regs pc=%h addr=%h want 0000/%h", instr_pc, imem_addr, RESET_PC);
        end
`ifdef IFU_PERF_CNT_EN
        checks++;
        if (flush_count !== 16'h0) begin failures++; $display("FAIL t6_flush_count got=%h want=0000", flush_count); end
`endif
        next_cycle();
        rst = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== (k >= 3)) begin
                failures++; $display("FAIL t6_restart cycle=%0d got=%b want=%b", k, instr_valid, k >= 3);
            end
            if (k == 3) begin
                checks++;
                if (instr_pc !== RESET_PC) begin failures++; $display("FAIL t6_restart_pc got=%h want=%h", instr_pc, RESET_PC); end
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        int p0;
        int nred;
`ifdef IFU_PERF_CNT_EN
        logic [15:0] fc0;
        fc0 = flush_count;
`endif
        p0 = pops; nred = 0;
        for (int k = 0; k < 400; k++) begin
            instr_ready    = ($urandom_range(0, 99) < 70);
            redirect_valid = ($urandom_range(0, 99) < 4);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? {OP_RET, 12'($urandom)} : 16'($urandom);
            if (redirect_valid) nred++;
            next_cycle();
        end
        redirect_valid = 0; instr_ready = 1;
        next_cycle();
        checks++;
        if (pops - p0 < 100) begin failures++; $display("FAIL rand_progress got=%0d want>=100", pops - p0); end
`ifdef IFU_PERF_CNT_EN
        checks++;
        if (flush_count !== fc0 + 16'(nred)) begin
            failures++; $display("FAIL rand_flush_count got=%h want=%h", flush_count, fc0 + 16'(nred));
        end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        seed = 16'($urandom);
        test_reset();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_random();
        test_mid_reset();
        repeat (3) next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
